// File: rtl/ssm_fetch_pkg.sv
// Shared types and constants for the SSM fetch/decode/dispatch sequencer.
// Holds the FSM state encoding, fault codes and the default opcode-to-unit dispatch map.
package ssm_fetch_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPcOut,
        StMemReq,
        StIrLoad,
        StDecode,
        StDispatch,
        StWaitDone,
        StFault
    } fetch_state_e;

    localparam logic [1:0] FaultNone = 2'd0;
    localparam logic [1:0] FaultMfc  = 2'd1;
    localparam logic [1:0] FaultDone = 2'd2;

    localparam int unsigned DefaultOpcodeW  = 4;
    localparam int unsigned DefaultNumUnits = 4;

    // One nibble per opcode, opcode 0 in the low nibble:
    // 1-7 -> unit0, 8-9 -> unit1, A-B -> unit2, C-D -> unit3, 0/E/F illegal.
    localparam logic [63:0] DefaultDispatchMap = 64'h0088_4422_1111_1110;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Saturating cycle counter with synchronous clear and a terminal-count flag.
// tc is high while the count is at or above the supplied terminal value.
module fetch_timeout_ctr #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal,
    output logic             tc
);

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + One;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q >= terminal);

endmodule

// File: rtl/instruction_fetch_ctrl.sv
// Fetch/decode/dispatch sequencer: reads one instruction word over the EN/R_W/MFC handshake,
// starts the execution unit mapped to its opcode and waits for that unit's done.
module instruction_fetch_ctrl
    import ssm_fetch_pkg::*;
#(
    parameter int unsigned OPCODE_W     = DefaultOpcodeW,
    parameter int unsigned NUM_UNITS    = DefaultNumUnits,
    parameter logic [(2**OPCODE_W)*NUM_UNITS-1:0] DISPATCH_MAP = DefaultDispatchMap,
    parameter int unsigned MFC_TIMEOUT  = 15,
    parameter int unsigned DONE_TIMEOUT = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 step_mode,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic                 mem_mfc,
    input  logic [NUM_UNITS-1:0] unit_done,
    output logic                 pc_out_en,
    output logic                 pc_inc_en,
    output logic                 mar_in_en,
    output logic                 mem_en,
    output logic                 mem_rw,
    output logic                 mdr_out_en,
    output logic                 ir_in_en,
    output logic [NUM_UNITS-1:0] unit_start,
    output logic                 busy,
    output logic                 illegal_op,
    output logic                 fault,
    output logic [1:0]           fault_code
);

    localparam int unsigned MaxTimeout = max_u(MFC_TIMEOUT, DONE_TIMEOUT);
    localparam int unsigned TimerW     = $clog2(MaxTimeout + 1);
    // Timer reads k-1 in the k-th cycle of a state, so the terminal is one below the limit.
    localparam logic [TimerW-1:0] MfcTerm  = TimerW'(MFC_TIMEOUT - 1);
    localparam logic [TimerW-1:0] DoneTerm = TimerW'(DONE_TIMEOUT - 1);

    fetch_state_e         state_q, state_d;
    logic [NUM_UNITS-1:0] sel_q, sel_d;
    logic [1:0]           fault_code_q, fault_code_d;
    logic [NUM_UNITS-1:0] map_entry;
    logic                 done_hit;
    logic                 timer_clear;
    logic                 timer_en;
    logic                 timer_tc;
    logic [TimerW-1:0]    timer_term;

    assign map_entry   = DISPATCH_MAP[int'(opcode) * NUM_UNITS +: NUM_UNITS];
    assign done_hit    = |(unit_done & sel_q);
    assign timer_clear = (state_d != state_q);
    assign timer_en    = (state_q == StMemReq) || (state_q == StWaitDone);
    assign timer_term  = (state_q == StMemReq) ? MfcTerm : DoneTerm;

    fetch_timeout_ctr #(
        .WIDTH(TimerW)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (timer_clear),
        .enable   (timer_en),
        .terminal (timer_term),
        .tc       (timer_tc)
    );

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        fault_code_d = fault_code_q;
        case (state_q)
            StIdle: begin
                if (start) state_d = StPcOut;
            end
            StPcOut: state_d = StMemReq;
            StMemReq: begin
                // A completing handshake beats a timeout landing on the same cycle.
                if (mem_mfc) begin
                    state_d = StIrLoad;
                end else if (timer_tc) begin
                    state_d      = StFault;
                    fault_code_d = FaultMfc;
                end
            end
            StIrLoad: state_d = StDecode;
            StDecode: begin
                sel_d   = map_entry;
                state_d = StDispatch;
            end
            StDispatch: begin
                if (sel_q == '0) begin
                    state_d = step_mode ? StIdle : StPcOut;
                end else begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (done_hit) begin
                    state_d = step_mode ? StIdle : StPcOut;
                end else if (timer_tc) begin
                    state_d      = StFault;
                    fault_code_d = FaultDone;
                end
            end
            StFault: state_d = StFault;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            sel_q        <= '0;
            fault_code_q <= FaultNone;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            fault_code_q <= fault_code_d;
        end
    end

    always_comb begin
        pc_out_en  = 1'b0;
        pc_inc_en  = 1'b0;
        mar_in_en  = 1'b0;
        mem_en     = 1'b0;
        mem_rw     = 1'b0;
        mdr_out_en = 1'b0;
        ir_in_en   = 1'b0;
        unit_start = '0;
        illegal_op = 1'b0;
        busy       = 1'b1;
        fault      = 1'b0;
        case (state_q)
            StIdle: busy = 1'b0;
            StPcOut: begin
                pc_out_en = 1'b1;
                mar_in_en = 1'b1;
            end
            StMemReq: begin
                mem_en = 1'b1;
                mem_rw = 1'b1;
            end
            StIrLoad: begin
                mem_en     = 1'b1;
                mem_rw     = 1'b1;
                mdr_out_en = 1'b1;
                ir_in_en   = 1'b1;
                pc_inc_en  = 1'b1;
            end
            StDispatch: begin
                unit_start = sel_q;
                illegal_op = (sel_q == '0);
            end
            StFault: begin
                busy  = 1'b0;
                fault = 1'b1;
            end
            default: ;
        endcase
    end

    assign fault_code = fault_code_q;

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Scenario bench for instruction_fetch_ctrl: expected unit vectors are queued when an opcode
// is issued and popped when the sequencer dispatches.
module tb_instruction_fetch_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       step_mode = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic       mem_mfc = 1'b1;
    logic [3:0] unit_done = 4'h0;

    logic       pc_out_en, pc_inc_en, mar_in_en, mem_en, mem_rw, mdr_out_en, ir_in_en;
    logic [3:0] unit_start;
    logic       busy, illegal_op, fault;
    logic [1:0] fault_code;

    int         n_checks = 0;
    int         n_fail = 0;
    int         start_seen = 0;
    int         illegal_seen = 0;
    logic [3:0] exp_q[$];

    instruction_fetch_ctrl #(
        .OPCODE_W     (4),
        .NUM_UNITS    (4),
        .MFC_TIMEOUT  (15),
        .DONE_TIMEOUT (255)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .step_mode  (step_mode),
        .opcode     (opcode),
        .mem_mfc    (mem_mfc),
        .unit_done  (unit_done),
        .pc_out_en  (pc_out_en),
        .pc_inc_en  (pc_inc_en),
        .mar_in_en  (mar_in_en),
        .mem_en     (mem_en),
        .mem_rw     (mem_rw),
        .mdr_out_en (mdr_out_en),
        .ir_in_en   (ir_in_en),
        .unit_start (unit_start),
        .busy       (busy),
        .illegal_op (illegal_op),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (unit_start != 4'h0) start_seen <= start_seen + 1;
        if (illegal_op === 1'b1) illegal_seen <= illegal_seen + 1;
    end

    function automatic logic [3:0] ref_unit(input logic [3:0] op);
        if (op >= 4'h1 && op <= 4'h7) return 4'b0001;
        if (op == 4'h8 || op == 4'h9) return 4'b0010;
        if (op == 4'hA || op == 4'hB) return 4'b0100;
        if (op == 4'hC || op == 4'hD) return 4'b1000;
        return 4'b0000;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [6:0] enables();
        return {pc_out_en, pc_inc_en, mar_in_en, mem_en, mem_rw, mdr_out_en, ir_in_en};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (fault !== 1'b0 || fault_code !== 2'd0) begin
            n_fail++; $display("FAIL reset_fault: got %b/%0d expected 0/0", fault, fault_code);
        end
        n_checks++;
        if (enables() !== 7'h0 || unit_start !== 4'h0 || illegal_op !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b/%b expected all 0", enables(), unit_start);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_hold: got %b expected 0", busy); end
    endtask

    task automatic test_single_step();
        logic [3:0] exp;
        step_mode = 1'b1;
        mem_mfc   = 1'b1;
        opcode    = 4'h1;
        exp_q.push_back(ref_unit(4'h1));
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (pc_out_en !== 1'b1 || mar_in_en !== 1'b1) begin
            n_fail++; $display("FAIL c1_pc_out: got %b%b expected 11", pc_out_en, mar_in_en);
        end
        tick();
        n_checks++;
        if (mem_en !== 1'b1 || mem_rw !== 1'b1 || pc_out_en !== 1'b0) begin
            n_fail++; $display("FAIL c2_mem_req: got %b%b%b expected 110", mem_en, mem_rw, pc_out_en);
        end
        tick();
        n_checks++;
        if (pc_inc_en !== 1'b1 || ir_in_en !== 1'b1 || mdr_out_en !== 1'b1) begin
            n_fail++; $display("FAIL c3_ir_load: got %b%b%b expected 111", pc_inc_en, ir_in_en, mdr_out_en);
        end
        tick();
        n_checks++;
        if (pc_inc_en !== 1'b0 || unit_start !== 4'h0) begin
            n_fail++; $display("FAIL c4_decode: got %b/%b expected 0/0000", pc_inc_en, unit_start);
        end
        tick();
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
        n_checks++;
        if (unit_start !== exp) begin
            n_fail++; $display("FAIL c5_unit_start: got %b expected %b", unit_start, exp);
        end
        tick();
        n_checks++;
        if (unit_start !== 4'h0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL c6_wait: got %b/%b expected 0000/1", unit_start, busy);
        end
        tick();
        tick();
        unit_done = 4'b0001;
        tick();
        unit_done = 4'b0000;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL c9_idle: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp;
        int waited;
        int gap;
        logic left_busy;
        step_mode = 1'b0;
        opcode    = 4'h8;
        exp_q.push_back(ref_unit(4'h8));
        start = 1'b1;
        tick();
        start = 1'b0;
        waited = 0;
        while (unit_start === 4'h0 && waited < 20) begin tick(); waited++; end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
        n_checks++;
        if (unit_start !== exp) begin
            n_fail++; $display("FAIL b2b_first: got %b expected %b", unit_start, exp);
        end
        left_busy = 1'b0;
        tick();
        if (busy !== 1'b1) left_busy = 1'b1;
        tick();
        if (busy !== 1'b1) left_busy = 1'b1;
        unit_done = 4'b0010;
        opcode    = 4'hC;
        exp_q.push_back(ref_unit(4'hC));
        tick();
        unit_done = 4'b0000;
        gap = 3;
        while (unit_start === 4'h0 && gap < 20) begin
            if (busy !== 1'b1) left_busy = 1'b1;
            tick();
            gap++;
        end
        n_checks++;
        if (gap != 7) begin n_fail++; $display("FAIL b2b_gap: got %0d expected 7", gap); end
        n_checks++;
        if (left_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_no_idle: got %b expected 0", left_busy); end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
        n_checks++;
        if (unit_start !== exp) begin
            n_fail++; $display("FAIL b2b_second: got %b expected %b", unit_start, exp);
        end
        step_mode = 1'b1;
        tick();
        tick();
        unit_done = 4'b1000;
        tick();
        unit_done = 4'b0000;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_stop: got %b expected 0", busy); end
    endtask

    task automatic test_illegal();
        logic [3:0] exp;
        int waited;
        int ill0;
        int st0;
        step_mode = 1'b1;
        opcode    = 4'hF;
        exp_q.push_back(ref_unit(4'hF));
        ill0 = illegal_seen;
        st0  = start_seen;
        start = 1'b1;
        tick();
        start = 1'b0;
        waited = 0;
        while (unit_start === 4'h0 && illegal_op !== 1'b1 && waited < 20) begin tick(); waited++; end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
        n_checks++;
        if (illegal_op !== 1'b1 || unit_start !== exp) begin
            n_fail++; $display("FAIL illegal_pulse: got %b/%b expected 1/%b", illegal_op, unit_start, exp);
        end
        tick();
        n_checks++;
        if (illegal_op !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL illegal_idle: got %b/%b expected 0/0", illegal_op, busy);
        end
        tick();
        tick();
        n_checks++;
        if (illegal_seen - ill0 != 1) begin
            n_fail++; $display("FAIL illegal_count: got %0d expected 1", illegal_seen - ill0);
        end
        n_checks++;
        if (start_seen != st0) begin
            n_fail++; $display("FAIL illegal_no_start: got %0d expected %0d", start_seen, st0);
        end
    endtask

    task automatic test_mfc_timeout();
        int n;
        mem_mfc   = 1'b0;
        step_mode = 1'b1;
        opcode    = 4'h1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n = 0;
        while (mem_en === 1'b1 && n < 40) begin n++; tick(); end
        n_checks++;
        if (n != 15) begin n_fail++; $display("FAIL mfc_timeout_cycles: got %0d expected 15", n); end
        n_checks++;
        if (fault !== 1'b1 || fault_code !== 2'd1) begin
            n_fail++; $display("FAIL mfc_fault_code: got %b/%0d expected 1/1", fault, fault_code);
        end
        n_checks++;
        if (mem_en !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mfc_fault_outputs: got %b/%b expected 0/0", mem_en, busy);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_checks++;
        if (fault !== 1'b1 || pc_out_en !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL fault_sticky: got %b/%b/%b expected 1/0/0", fault, pc_out_en, busy);
        end
        reset   = 1'b1;
        mem_mfc = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (fault !== 1'b0 || fault_code !== 2'd0) begin
            n_fail++; $display("FAIL fault_cleared: got %b/%0d expected 0/0", fault, fault_code);
        end
    endtask

    task automatic test_done_timeout();
        logic [3:0] exp;
        int waited;
        step_mode = 1'b1;
        mem_mfc   = 1'b1;
        opcode    = 4'h5;
        exp_q.push_back(ref_unit(4'h5));
        start = 1'b1;
        tick();
        start = 1'b0;
        waited = 0;
        while (unit_start === 4'h0 && waited < 20) begin tick(); waited++; end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
        n_checks++;
        if (unit_start !== exp) begin
            n_fail++; $display("FAIL dto_start: got %b expected %b", unit_start, exp);
        end
        tick();
        tick();
        unit_done = 4'b0100;
        tick();
        unit_done = 4'b0000;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL foreign_done_ignored: got %b expected 1", busy); end
        for (int i = 3; i < 255; i++) tick();
        n_checks++;
        if (busy !== 1'b1 || fault !== 1'b0) begin
            n_fail++; $display("FAIL pre_timeout: got %b/%b expected 1/0", busy, fault);
        end
        unit_done = 4'b0001;
        tick();
        unit_done = 4'b0000;
        n_checks++;
        if (busy !== 1'b0 || fault !== 1'b0 || fault_code !== 2'd0) begin
            n_fail++; $display("FAIL done_wins: got %b/%b/%0d expected 0/0/0", busy, fault, fault_code);
        end
    endtask

    task automatic test_done_fault();
        logic [3:0] exp;
        int waited;
        int n;
        opcode = 4'h9;
        exp_q.push_back(ref_unit(4'h9));
        start = 1'b1;
        tick();
        start = 1'b0;
        waited = 0;
        while (unit_start === 4'h0 && waited < 20) begin tick(); waited++; end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
        n_checks++;
        if (unit_start !== exp) begin
            n_fail++; $display("FAIL dfault_start: got %b expected %b", unit_start, exp);
        end
        tick();
        n = 0;
        while (busy === 1'b1 && n < 300) begin n++; tick(); end
        n_checks++;
        if (n != 255) begin n_fail++; $display("FAIL done_timeout_cycles: got %0d expected 255", n); end
        n_checks++;
        if (fault !== 1'b1 || fault_code !== 2'd2) begin
            n_fail++; $display("FAIL done_fault_code: got %b/%0d expected 1/2", fault, fault_code);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset_mid();
        int st0;
        mem_mfc = 1'b0;
        opcode  = 4'h1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_checks++;
        if (mem_en !== 1'b1) begin n_fail++; $display("FAIL mid_in_mem_req: got %b expected 1", mem_en); end
        st0     = start_seen;
        reset   = 1'b1;
        mem_mfc = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0 || enables() !== 7'h0 || unit_start !== 4'h0) begin
            n_fail++; $display("FAIL mid_reset_abort: got %b/%b/%b expected 0/0/0", busy, enables(), unit_start);
        end
        reset = 1'b0;
        repeat (10) tick();
        n_checks++;
        if (start_seen != st0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_no_start: got %0d/%b expected %0d/0", start_seen, busy, st0);
        end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_back_to_back();
        test_illegal();
        test_mfc_timeout();
        test_done_timeout();
        test_done_fault();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
